// File: rtl/secded_dec_pipe_if.sv
// secded_dec_pipe_if: valid/ready bundle for the read-return side and the consumer side of the SECDED decoder.
interface secded_dec_pipe_if #(
    parameter int DATA_W = 32
);
    function automatic int calc_r(int dw);
        int r = 1;
        while ((1 << r) < dw + r + 1) r++;
        return r;
    endfunction
    localparam int R = calc_r(DATA_W);
    localparam int PAR_W = R + 1;
    logic in_valid, in_ready, out_valid, out_ready, out_single_err, out_double_err;
    logic [DATA_W-1:0] in_data, out_data;
    logic [PAR_W-1:0] in_parity;
    logic [R-1:0] out_syndrome;
    modport master (
        output in_valid, in_data, in_parity, out_ready,
        input in_ready, out_valid, out_data, out_single_err, out_double_err, out_syndrome
    );
    modport slave (
        input in_valid, in_data, in_parity, out_ready,
        output in_ready, out_valid, out_data, out_single_err, out_double_err, out_syndrome
    );
endinterface

// File: rtl/secded_dec_pipe.sv
// secded_dec_pipe: two-stage pipelined SECDED Hamming decoder with valid/ready on both sides.
// Define SECDED_ERR_CNT_EN to build the saturating single/double error counters.
module secded_dec_pipe #(
    parameter int DATA_W = 32,
    parameter int COUNT_W = 16
) (
    input logic clk,
    input logic rst_n,
    secded_dec_pipe_if.slave bus,
    input logic cnt_clr,
    output logic [COUNT_W-1:0] single_cnt,
    output logic [COUNT_W-1:0] double_cnt
);
    function automatic int calc_r(int dw);
        int r = 1;
        while ((1 << r) < dw + r + 1) r++;
        return r;
    endfunction
    // Codeword position of data bit j: the j-th position that is not a power of two, starting at 3.
    function automatic int dpos(int j);
        int p = 2;
        int k = -1;
        while (k < j) begin
            p++;
            if ((p & (p - 1)) != 0) k++;
        end
        return p;
    endfunction
    localparam int R = calc_r(DATA_W);
    localparam int N = DATA_W + R;
    logic s1_valid, s2_valid, s1_ready, s2_ready, s1_ov, single_c, double_c;
    logic [DATA_W-1:0] s1_data, fix_mask;
    logic [R-1:0] s1_syn, syn;
    assign s2_ready = !s2_valid || bus.out_ready;
    assign s1_ready = !s1_valid || s2_ready;
    assign bus.in_ready = s1_ready;
    assign bus.out_valid = s2_valid;
    // The syndrome is the XOR of the positions of every set codeword bit.
    always_comb begin
        syn = bus.in_parity[R-1:0];
        for (int j = 0; j < DATA_W; j++) syn ^= bus.in_data[j] ? R'(dpos(j)) : '0;
    end
    always_comb begin
        fix_mask = '0;
        for (int j = 0; j < DATA_W; j++) fix_mask[j] = s1_ov && s1_syn == R'(dpos(j));
    end
    assign single_c = s1_ov && 32'(s1_syn) <= 32'(N);
    assign double_c = s1_ov ? 32'(s1_syn) > 32'(N) : s1_syn != '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data <= '0;
            s1_syn <= '0;
            s1_ov <= 1'b0;
        end else begin
            if (s1_ready) s1_valid <= bus.in_valid;
            if (s1_ready && bus.in_valid) begin
                s1_data <= bus.in_data;
                s1_syn <= syn;
                s1_ov <= ^{bus.in_data, bus.in_parity};
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            bus.out_data <= '0;
            bus.out_single_err <= 1'b0;
            bus.out_double_err <= 1'b0;
            bus.out_syndrome <= '0;
        end else begin
            if (s2_ready) s2_valid <= s1_valid;
            if (s2_ready && s1_valid) begin
                bus.out_data <= s1_data ^ fix_mask;
                bus.out_single_err <= single_c;
                bus.out_double_err <= double_c;
                bus.out_syndrome <= s1_syn;
            end
        end
    end
`ifdef SECDED_ERR_CNT_EN
    logic hs;
    assign hs = s2_valid && bus.out_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            single_cnt <= '0;
            double_cnt <= '0;
        end else if (cnt_clr) begin
            single_cnt <= '0;
            double_cnt <= '0;
        end else if (hs) begin
            if (bus.out_single_err && !(&single_cnt)) single_cnt <= single_cnt + 1'b1;
            if (bus.out_double_err && !(&double_cnt)) double_cnt <= double_cnt + 1'b1;
        end
    end
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign single_cnt = '0;
    assign double_cnt = '0;
`endif
endmodule

// File: tb/tb_secded_dec_pipe.sv
// tb_secded_dec_pipe: table-driven and scoreboarded checks of the pipelined SECDED decoder (DATA_W=32, COUNT_W=2).
module tb_secded_dec_pipe;
    localparam int DW = 32;
    localparam int R = 6;
    localparam int N = DW + R;
`ifdef SECDED_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    typedef struct {
        logic [31:0] in_data;
        logic [6:0] in_parity;
        logic [31:0] exp_data;
        logic exp_s;
        logic exp_d;
        logic [5:0] exp_syn;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cnt_clr = 1'b0;
    logic [1:0] single_cnt, double_cnt;
    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int m_single = 0;
    int m_double = 0;
    vec_t q[$];
    vec_t cur, e_pop;
    vec_t tbl[14];
    logic prev_stall = 1'b0;
    logic prev_s, prev_d;
    logic [31:0] prev_data;
    logic [5:0] prev_syn;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    secded_dec_pipe_if #(.DATA_W(DW)) bus();
    secded_dec_pipe #(.DATA_W(DW), .COUNT_W(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .cnt_clr(cnt_clr),
        .single_cnt(single_cnt),
        .double_cnt(double_cnt)
    );
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask
    // Reference encoder: build a clean codeword, flip the requested positions (0 = overall parity, -1 = none).
    function automatic vec_t mk(logic [31:0] d, int e1, int e2, int e3);
        logic [N:0] cw;
        int k, ne;
        int e[3];
        vec_t v;
        cw = '0;
        k = 0;
        ne = 0;
        e = '{e1, e2, e3};
        for (int p = 1; p <= N; p++)
            if ((p & (p - 1)) != 0) begin
                cw[p] = d[k];
                k++;
            end
        for (int i = 0; i < R; i++)
            for (int p = 1; p <= N; p++)
                if (((p >> i) & 1) == 1 && p != (1 << i)) cw[1 << i] ^= cw[p];
        cw[0] = ^cw[N:1];
        v.exp_syn = '0;
        foreach (e[j])
            if (e[j] >= 0) begin
                cw[e[j]] = ~cw[e[j]];
                ne++;
                v.exp_syn ^= 6'(e[j]);
            end
        k = 0;
        for (int p = 1; p <= N; p++)
            if ((p & (p - 1)) != 0) begin
                v.in_data[k] = cw[p];
                k++;
            end
        for (int i = 0; i < R; i++) v.in_parity[i] = cw[1 << i];
        v.in_parity[R] = cw[0];
        v.exp_data = ne >= 2 ? v.in_data : d;
        v.exp_s = ne == 1;
        v.exp_d = ne >= 2;
        return v;
    endfunction
    always @(negedge clk) begin
        if (!rst_n) begin
            m_single = 0;
            m_double = 0;
            prev_stall = 1'b0;
        end else begin
            chk("single_cnt", 32'(single_cnt), CNT_EN ? m_single : 0);
            chk("double_cnt", 32'(double_cnt), CNT_EN ? m_double : 0);
            chk("in_ready", 32'(bus.in_ready), 32'(!(q.size() == 2 && !bus.out_ready)));
            if (prev_stall) begin
                chk("hold_valid", 32'(bus.out_valid), 1);
                chk("hold_data", bus.out_data, prev_data);
                chk("hold_flags", {bus.out_single_err, bus.out_double_err}, {prev_s, prev_d});
                chk("hold_syn", 32'(bus.out_syndrome), 32'(prev_syn));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_output: got data %h, expected no word", bus.out_data);
                end else begin
                    e_pop = q.pop_front();
                    chk("out_data", bus.out_data, e_pop.exp_data);
                    chk("single_err", 32'(bus.out_single_err), 32'(e_pop.exp_s));
                    chk("double_err", 32'(bus.out_double_err), 32'(e_pop.exp_d));
                    chk("syndrome", 32'(bus.out_syndrome), 32'(e_pop.exp_syn));
                    if (!cnt_clr) begin
                        if (e_pop.exp_s && m_single < 3) m_single++;
                        if (e_pop.exp_d && m_double < 3) m_double++;
                    end
                end
            end
            if (cnt_clr) begin
                m_single = 0;
                m_double = 0;
            end
            if (bus.in_valid && bus.in_ready) q.push_back(cur);
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data = bus.out_data;
            prev_s = bus.out_single_err;
            prev_d = bus.out_double_err;
            prev_syn = bus.out_syndrome;
        end
    end
    task automatic send(vec_t v);
        int n = 0;
        logic ok;
        bus.in_valid = 1'b1;
        bus.in_data = v.in_data;
        bus.in_parity = v.in_parity;
        cur = v;
        do begin
            @(negedge clk);
            ok = bus.in_ready;
            n++;
            @(posedge clk);
            #1;
        end while (!ok && n < 200);
        if (!ok) begin
            checks++;
            fails++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles, expected acceptance", n);
        end
    endtask
    task automatic drain();
        int n = 0;
        bus.in_valid = 1'b0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_left", q.size(), 0);
    endtask
    task automatic pulse_clr();
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
    endtask
    initial begin
        int t0, n;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_parity = '0;
        bus.out_ready = 1'b1;
        tbl[0] = '{32'h1, 7'h00, 32'h0, 1'b1, 1'b0, 6'd3};
        tbl[1] = '{32'h3, 7'h00, 32'h3, 1'b0, 1'b1, 6'd6};
        tbl[2] = '{32'h0, 7'b0000001, 32'h0, 1'b1, 1'b0, 6'd1};
        tbl[3] = '{32'h0, 7'b1000000, 32'h0, 1'b1, 1'b0, 6'd0};
        tbl[4] = mk(32'hDEADBEEF, -1, -1, -1);
        tbl[5] = mk(32'hFFFFFFFF, -1, -1, -1);
        tbl[6] = mk(32'h12345678, 7, -1, -1);
        tbl[7] = mk(32'hA5A5A5A5, 38, -1, -1);
        tbl[8] = mk(32'h0F0F0F0F, 32, -1, -1);
        tbl[9] = mk(32'hCAFEF00D, 0, -1, -1);
        tbl[10] = mk(32'h55AA55AA, 3, 38, -1);
        tbl[11] = mk(32'h13579BDF, 5, 16, -1);
        tbl[12] = mk(32'h2468ACE0, 32, 8, 1);
        tbl[13] = mk(32'h0, 0, 3, -1);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_flags", {bus.out_single_err, bus.out_double_err}, 0);
        chk("rst_syndrome", 32'(bus.out_syndrome), 0);
        chk("rst_single_cnt", 32'(single_cnt), 0);
        chk("rst_double_cnt", 32'(double_cnt), 0);
        rst_n = 1'b1;
        chk("in_ready_after_reset", 32'(bus.in_ready), 1);
        for (int i = 0; i < 14; i++) send(tbl[i]);
        drain();
        pulse_clr();
        fork
            for (int i = 0; i < 8; i++) send(mk($urandom, (i % 2 == 1) ? i * 4 + 1 : -1, -1, -1));
            for (int c = 0; c < 40; c++) begin
                bus.out_ready = (c % 4 == 0) || (c % 4 == 3);
                @(posedge clk);
                #1;
            end
        join
        bus.out_ready = 1'b1;
        drain();
        pulse_clr();
        chk("clr_alone", 32'(single_cnt), 0);
        for (int i = 0; i < 5; i++) send(mk(32'h100 << i, 9 + i, -1, -1));
        drain();
        @(posedge clk);
        #1;
        chk("single_sat", 32'(single_cnt), CNT_EN ? 3 : 0);
        chk("double_after_sat", 32'(double_cnt), 0);
        bus.out_ready = 1'b0;
        send(mk(32'h1, 3, -1, -1));
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        pulse_clr();
        chk("clr_wins", 32'(single_cnt), 0);
        drain();
        send(mk(32'hFACE0001, 10, -1, -1));
        drain();
        bus.out_ready = 1'b0;
        send(mk(32'h11111111, 12, -1, -1));
        send(mk(32'h22222222, 20, 21, -1));
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 0);
        chk("midrst_single_cnt", 32'(single_cnt), 0);
        chk("midrst_double_cnt", 32'(double_cnt), 0);
        q.delete();
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("in_ready_after_midrst", 32'(bus.in_ready), 1);
        t0 = cyc;
        send(mk(32'h87654321, 20, -1, -1));
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", cyc - t0, 2);
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
